// File: rtl/im_addr_arbiter_pkg.sv
// Arbiter-local types and helpers for the IM address arbiter.
package im_addr_arbiter_pkg;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } burst_state_e;

    // Next round-robin position after idx, wrapping at n.
    function automatic int rr_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/im_addr_arbiter_rr_priority_picker.sv
// Combinational round-robin priority pick: first set request at or after ptr_i.
module rr_priority_picker
    import im_addr_arbiter_pkg::*;
#(
    parameter int NumReq  = 4,
    parameter int IdWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]  req_i,
    input  logic [IdWidth-1:0] ptr_i,
    output logic [NumReq-1:0]  onehot_o,
    output logic [IdWidth-1:0] idx_o,
    output logic               found_o
);

    logic [IdWidth-1:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        cand     = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = IdWidth'((int'(ptr_i) + i) % NumReq);
            if (!found_o && req_i[cand]) begin
                found_o        = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/im_addr_arbiter.sv
// Round-robin arbiter with burst locking sharing one IM read-address port
// among NumReq slicer address streams; one-entry registered output stage.
module im_addr_arbiter
    import im_addr_arbiter_pkg::*;
#(
    parameter int NumReq       = 4,
    parameter int NumTotIm     = 1024,
    parameter int CsrDataWidth = 32,
    parameter int ImAddrWidth  = $clog2(NumTotIm),
    parameter int IdWidth      = $clog2(NumReq)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                enable_i,
    input  logic                                clr_i,
    input  logic [CsrDataWidth-1:0]             csr_burst_len_i,
    input  logic [NumReq-1:0][ImAddrWidth-1:0]  req_addr_i,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    output logic [ImAddrWidth-1:0]              addr_o,
    output logic [IdWidth-1:0]                  id_o,
    output logic                                addr_valid_o,
    input  logic                                addr_ready_i,
    output logic                                busy_o
);

    burst_state_e            state_q, state_d;
    logic [IdWidth-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IdWidth-1:0]      grant_q, grant_d;
    logic [CsrDataWidth-1:0] cnt_q, cnt_d;
    logic [CsrDataWidth-1:0] eff_len;
    logic [CsrDataWidth:0]   cnt_inc;

    logic [ImAddrWidth-1:0]  addr_q;
    logic [IdWidth-1:0]      id_q;
    logic                    valid_q;

    logic [NumReq-1:0]       pick_oh, grant_oh;
    logic [IdWidth-1:0]      pick_idx, win_idx;
    logic                    pick_found, win_valid, locked, load, accept;

    rr_priority_picker #(
        .NumReq  (NumReq),
        .IdWidth (IdWidth)
    ) u_picker (
        .req_i    (req_valid_i),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    assign locked    = (state_q == ST_LOCKED);
    assign eff_len   = (csr_burst_len_i == '0) ? CsrDataWidth'(1) : csr_burst_len_i;
    assign cnt_inc   = {1'b0, cnt_q} + (CsrDataWidth + 1)'(1);
    assign load      = enable_i && !clr_i && (!valid_q || addr_ready_i);
    assign grant_oh  = NumReq'(1) << grant_q;
    assign win_idx   = locked ? grant_q : pick_idx;
    assign win_valid = locked ? req_valid_i[grant_q] : pick_found;
    assign accept    = load && win_valid;

    // While locked the holder is offered the port even if it has gone idle.
    assign req_ready_o = !load ? '0 : (locked ? grant_oh : pick_oh);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            state_d  = ST_UNLOCKED;
            rr_ptr_d = '0;
            cnt_d    = '0;
        end else if (enable_i) begin
            unique case (state_q)
                ST_UNLOCKED: begin
                    if (accept) begin
                        if (eff_len > CsrDataWidth'(1)) begin
                            state_d = ST_LOCKED;
                            grant_d = win_idx;
                            cnt_d   = CsrDataWidth'(1);
                        end else begin
                            rr_ptr_d = IdWidth'(rr_inc(32'(win_idx), NumReq));
                        end
                    end
                end
                ST_LOCKED: begin
                    // ">=" also releases when the length was lowered mid-burst.
                    if (!req_valid_i[grant_q] ||
                        (accept && cnt_inc >= {1'b0, eff_len})) begin
                        state_d  = ST_UNLOCKED;
                        rr_ptr_d = IdWidth'(rr_inc(32'(grant_q), NumReq));
                        cnt_d    = '0;
                    end else if (accept) begin
                        cnt_d = cnt_inc[CsrDataWidth-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_UNLOCKED;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
        end
    end

    // Output stage reloads on a same-cycle pop and accept, so no bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr_i[win_idx];
            id_q    <= win_idx;
            valid_q <= 1'b1;
        end else if (addr_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign addr_o       = addr_q;
    assign id_o         = id_q;
    assign addr_valid_o = valid_q;
    assign busy_o       = valid_q || (|req_valid_i) || locked;

endmodule

// File: tb/tb_im_addr_arbiter.sv
// Self-checking bench for im_addr_arbiter: directed scenarios plus random traffic
// checked against a transfer-level reference model.
module tb_im_addr_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               rst_ni;
    logic               en, clr, ardy;
    logic [31:0]        bl;
    logic [N-1:0][AW-1:0] addrs;
    logic [N-1:0]       vld;
    logic [N-1:0]       req_ready_o;
    logic [AW-1:0]      addr_o;
    logic [IW-1:0]      id_o;
    logic               addr_valid_o, busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_lock, m_av;
    int          m_g, m_cnt, m_ptr;
    logic [AW-1:0] m_addr;
    logic [IW-1:0] m_id;
    logic [N-1:0] e_rdy;
    bit          e_busy;

    // Sampled DUT values
    logic [N-1:0]  g_rdy;
    logic          g_busy, g_av;
    logic [AW-1:0] g_addr;
    logic [IW-1:0] g_id;

    always #5 clk = ~clk;

    im_addr_arbiter #(.NumReq(N), .NumTotIm(1024), .CsrDataWidth(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .enable_i        (en),
        .clr_i           (clr),
        .csr_burst_len_i (bl),
        .req_addr_i      (addrs),
        .req_valid_i     (vld),
        .req_ready_o     (req_ready_o),
        .addr_o          (addr_o),
        .id_o            (id_o),
        .addr_valid_o    (addr_valid_o),
        .addr_ready_i    (ardy),
        .busy_o          (busy_o)
    );

    task automatic model_reset();
        m_lock = 0; m_av = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
        m_addr = '0; m_id = '0;
    endtask

    // One clock: predicts grant/ready from the arbitration rules, samples the
    // DUT before and after the edge, then advances the model.
    task automatic step();
        int  w, eff;
        bit  found, ld, acc;
        #1;
        eff   = (bl == 0) ? 1 : int'(bl);
        ld    = en && !clr && (!m_av || ardy);
        found = 0;
        w     = 0;
        if (m_lock) begin
            found = 1;
            w     = m_g;
        end else begin
            for (int k = 0; k < N; k++)
                if (!found && vld[(m_ptr + k) % N]) begin
                    found = 1;
                    w     = (m_ptr + k) % N;
                end
        end
        e_rdy  = (ld && found) ? N'(1 << w) : '0;
        e_busy = m_av || (vld != 0) || m_lock;
        acc    = ld && found && vld[w];
        g_rdy  = req_ready_o;
        g_busy = busy_o;
        @(posedge clk);
        if (clr) begin
            m_lock = 0; m_ptr = 0; m_cnt = 0; m_av = 0;
        end else begin
            if (acc) begin
                m_addr = addrs[w];
                m_id   = IW'(w);
                m_av   = 1;
            end else if (ardy) begin
                m_av = 0;
            end
            if (en) begin
                if (m_lock) begin
                    if (!vld[m_g] || (acc && m_cnt + 1 >= eff)) begin
                        m_lock = 0;
                        m_ptr  = (m_g + 1) % N;
                    end else if (acc) begin
                        m_cnt++;
                    end
                end else if (acc) begin
                    if (eff > 1) begin
                        m_lock = 1; m_g = w; m_cnt = 1;
                    end else begin
                        m_ptr = (w + 1) % N;
                    end
                end
            end
        end
        #1;
        g_av   = addr_valid_o;
        g_addr = addr_o;
        g_id   = id_o;
    endtask

    task automatic clear_pulse();
        clr = 1;
        step();
        n_tests++;
        if (g_rdy !== '0) begin
            n_fail++; $display("FAIL clr_ready got=%b exp=0000", g_rdy);
        end
        n_tests++;
        if (g_av !== 1'b0) begin
            n_fail++; $display("FAIL clr_valid got=%b exp=0", g_av);
        end
        clr = 0;
    endtask

    task automatic test_reset();
        rst_ni = 0; en = 0; clr = 0; ardy = 0; bl = 1; vld = '0; addrs = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_tests++;
        if (addr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", addr_valid_o); end
        n_tests++;
        if (addr_o !== '0) begin n_fail++; $display("FAIL rst_addr got=%0h exp=0", addr_o); end
        n_tests++;
        if (id_o !== '0) begin n_fail++; $display("FAIL rst_id got=%0d exp=0", id_o); end
        n_tests++;
        if (req_ready_o !== '0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0000", req_ready_o); end
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        rst_ni = 1;
    endtask

    task automatic test_round_robin();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        int exp_ad[5] = '{10, 20, 30, 40, 10};
        addrs[0] = 10; addrs[1] = 20; addrs[2] = 30; addrs[3] = 40;
        vld = 4'b1111; ardy = 1; bl = 1; en = 0;
        step();
        n_tests++;
        if (g_rdy !== '0 || g_av !== 1'b0) begin
            n_fail++; $display("FAIL rr_disabled got=%b/%b exp=0000/0", g_rdy, g_av);
        end
        en = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++;
            if (g_av !== 1'b1 || g_id !== IW'(exp_id[k]) || g_addr !== AW'(exp_ad[k])) begin
                n_fail++;
                $display("FAIL rr_seq[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", k, g_av, g_id, g_addr, exp_id[k], exp_ad[k]);
            end
            n_tests++;
            if (g_rdy !== e_rdy) begin n_fail++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, g_rdy, e_rdy); end
        end
    endtask

    task automatic test_burst();
        int exp_id[7] = '{1, 1, 1, 2, 2, 2, 1};
        clear_pulse();
        bl = 3; vld = 4'b0110; ardy = 1;
        for (int k = 0; k < 7; k++) begin
            step();
            n_tests++;
            if (g_av !== 1'b1 || g_id !== IW'(exp_id[k])) begin
                n_fail++; $display("FAIL burst_seq[%0d] got=%b/%0d exp=1/%0d", k, g_av, g_id, exp_id[k]);
            end
        end
    endtask

    task automatic test_drop_release();
        clear_pulse();
        bl = 4; vld = 4'b1001; ardy = 1;
        repeat (2) begin
            step();
            n_tests++;
            if (g_av !== 1'b1 || g_id !== 2'd0) begin
                n_fail++; $display("FAIL drop_hold got=%b/%0d exp=1/0", g_av, g_id);
            end
        end
        vld = 4'b1000;
        step();
        n_tests++;
        if (g_av !== 1'b0) begin n_fail++; $display("FAIL drop_idle got=%b exp=0", g_av); end
        step();
        n_tests++;
        if (g_av !== 1'b1 || g_id !== 2'd3) begin
            n_fail++; $display("FAIL drop_next got=%b/%0d exp=1/3", g_av, g_id);
        end
    endtask

    task automatic test_backpressure();
        clear_pulse();
        bl = 1; vld = 4'b0100; addrs[2] = 10'h155; ardy = 0;
        step();
        n_tests++;
        if (g_av !== 1'b1 || g_addr !== 10'h155 || g_id !== 2'd2) begin
            n_fail++; $display("FAIL bp_first got=%b/%0h/%0d exp=1/155/2", g_av, g_addr, g_id);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++;
            if (g_rdy !== '0 || g_av !== 1'b1 || g_addr !== 10'h155) begin
                n_fail++; $display("FAIL bp_hold[%0d] got=%b/%b/%0h exp=0000/1/155", k, g_rdy, g_av, g_addr);
            end
        end
        ardy = 1; vld = '0;
        step();
        n_tests++;
        if (g_av !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", g_av); end
    endtask

    task automatic test_clear();
        clear_pulse();
        bl = 1; vld = 4'b0010; ardy = 1;
        step();
        bl = 8; vld = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (g_av !== 1'b1 || g_id !== 2'd2) begin
                n_fail++; $display("FAIL clr_burst[%0d] got=%b/%0d exp=1/2", k, g_av, g_id);
            end
        end
        clear_pulse();
        step();
        n_tests++;
        if (g_av !== 1'b1 || g_id !== 2'd0) begin
            n_fail++; $display("FAIL clr_restart got=%b/%0d exp=1/0", g_av, g_id);
        end
    endtask

    task automatic test_zero_len_enable();
        clear_pulse();
        bl = 0; vld = 4'b1111; ardy = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_tests++;
            if (g_av !== 1'b1 || g_id !== IW'(k)) begin
                n_fail++; $display("FAIL zero_len[%0d] got=%b/%0d exp=1/%0d", k, g_av, g_id, k);
            end
        end
        ardy = 0; en = 0;
        step();
        n_tests++;
        if (g_rdy !== '0 || g_av !== 1'b1) begin
            n_fail++; $display("FAIL en_low_hold got=%b/%b exp=0000/1", g_rdy, g_av);
        end
        ardy = 1;
        step();
        n_tests++;
        if (g_rdy !== '0 || g_av !== 1'b0) begin
            n_fail++; $display("FAIL en_low_drain got=%b/%b exp=0000/0", g_rdy, g_av);
        end
        en = 1;
    endtask

    task automatic test_random();
        clear_pulse();
        for (int k = 0; k < 400; k++) begin
            en   = ($urandom % 8) != 0;
            clr  = ($urandom % 40) == 0;
            ardy = ($urandom % 4) != 0;
            vld  = N'($urandom);
            if (k % 50 == 0) bl = $urandom % 5;
            for (int i = 0; i < N; i++) addrs[i] = AW'($urandom);
            step();
            n_tests++;
            if (g_rdy !== e_rdy || g_busy !== e_busy) begin
                n_fail++; $display("FAIL rnd_comb[%0d] got=%b/%b exp=%b/%b", k, g_rdy, g_busy, e_rdy, e_busy);
            end
            n_tests++;
            if (g_av !== m_av || (m_av && (g_addr !== m_addr || g_id !== m_id))) begin
                n_fail++;
                $display("FAIL rnd_out[%0d] got=%b/%0h/%0d exp=%b/%0h/%0d", k, g_av, g_addr, g_id, m_av, m_addr, m_id);
            end
        end
        clr = 0;
    endtask

    task automatic test_async_reset();
        en = 1; clr = 0; ardy = 1; bl = 8; vld = 4'b1111;
        repeat (2) step();
        vld = '0;
        #3 rst_ni = 0;
        #1;
        n_tests++;
        if (addr_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== '0) begin
            n_fail++;
            $display("FAIL async_rst got=%b/%b/%b exp=0/0/0000", addr_valid_o, busy_o, req_ready_o);
        end
        model_reset();
        @(posedge clk);
        #1 rst_ni = 1;
        vld = 4'b0100; addrs[2] = 10'h2A;
        step();
        n_tests++;
        if (g_av !== 1'b1 || g_id !== 2'd2 || g_addr !== 10'h2A) begin
            n_fail++; $display("FAIL post_rst got=%b/%0d/%0h exp=1/2/2a", g_av, g_id, g_addr);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_drop_release();
        test_backpressure();
        test_clear();
        test_zero_len_enable();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
